// File: rtl/mips_unified_memory.sv
// Unified instruction/data memory responder for the MIPS core.
// One word array is shared by three ports:
//   - instruction port: combinational read
//   - data port: registered read and write
//   - host load port: valid/ready preload path
// A core write always takes the single write port. A host load is accepted only
// when the core is reading or idle. Misaligned and out-of-window accesses are
// reported as faults.

module mips_unified_memory #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_in,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  input  logic        data_rd_wr,
  output logic [31:0] data_in,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        fault,
  output logic [7:0]  fault_count,
  output logic [31:0] fault_addr
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WINDOW = 32'(4 * DEPTH_WORDS);

  logic [31:0] mem_q [DEPTH_WORDS];

  logic             rst_prev_q, rst_prev_d;
  logic [31:0]      data_in_q, data_in_d;
  logic             fault_q, fault_d;
  logic [7:0]       fault_count_q, fault_count_d;
  logic [31:0]      fault_addr_q, fault_addr_d;

  logic [31:0]      i_off, d_off, l_off;
  logic             i_ok, d_ok, l_ok;
  logic [IDX_W-1:0] i_idx, d_idx, l_idx;

  logic             load_acc;
  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [31:0]      mem_wdata;

  logic             ev_i, ev_d, ev_l;
  logic [8:0]       cnt_sum;

  // Address decode for all three ports. An address below BASE_ADDR wraps to a
  // huge offset, so it fails the window check.
  always_comb begin
    i_off = instr_addr - BASE_ADDR;
    d_off = data_addr  - BASE_ADDR;
    l_off = load_addr  - BASE_ADDR;
    i_ok  = (instr_addr[1:0] == 2'b00) && (i_off < WINDOW);
    d_ok  = (data_addr[1:0]  == 2'b00) && (d_off < WINDOW);
    l_ok  = (load_addr[1:0]  == 2'b00) && (l_off < WINDOW);
    i_idx = i_off[IDX_W+1:2];
    d_idx = d_off[IDX_W+1:2];
    l_idx = l_off[IDX_W+1:2];
  end

  // Instruction fetch reads the array directly. A same-cycle write to the same
  // word is seen only after the edge.
  assign instr_in = i_ok ? mem_q[i_idx] : 32'h0000_0000;

  // Ready is low only in the first cycle reset is asserted. A reset that is
  // held high still lets the host preload before the core starts.
  assign load_ready = data_rd_wr & ~(reset & ~rst_prev_q);
  assign load_acc   = load_valid & load_ready;

  // Single write-port arbitration: a core write wins, otherwise an accepted
  // host load is written.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = d_idx;
    mem_wdata = data_out;
    if (!data_rd_wr && d_ok && !reset) begin
      mem_we = 1'b1;
    end else if (load_acc && l_ok) begin
      mem_we    = 1'b1;
      mem_widx  = l_idx;
      mem_wdata = load_data;
    end
  end

  // Array storage, written on the clock edge. It has no reset, so contents
  // survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  // Next-state logic for the read register and the fault tracking.
  always_comb begin
    rst_prev_d    = reset;
    data_in_d     = data_in_q;
    fault_d       = fault_q;
    fault_count_d = fault_count_q;
    fault_addr_d  = fault_addr_q;

    // The core drives junk instruction addresses while in reset, so those
    // are not counted as faults.
    ev_i    = ~reset & ~i_ok;
    ev_d    = ~d_ok;
    ev_l    = load_acc & ~l_ok;
    cnt_sum = {1'b0, fault_count_q} + {8'b0, ev_i} + {8'b0, ev_d} + {8'b0, ev_l};

    if (data_rd_wr) data_in_d = d_ok ? mem_q[d_idx] : 32'h0000_0000;

    if (ev_i || ev_d || ev_l) begin
      fault_d       = 1'b1;
      fault_count_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
      if (ev_d)      fault_addr_d = data_addr;
      else if (ev_l) fault_addr_d = load_addr;
      else           fault_addr_d = instr_addr;
    end
  end

  // Control registers. rst_prev_q follows reset itself, so that the first
  // cycle of a reset can be told apart from later reset cycles.
  always_ff @(posedge clk) begin
    rst_prev_q <= rst_prev_d;
    if (reset) begin
      data_in_q     <= 32'h0000_0000;
      fault_q       <= 1'b0;
      fault_count_q <= 8'h00;
      fault_addr_q  <= 32'h0000_0000;
    end else begin
      data_in_q     <= data_in_d;
      fault_q       <= fault_d;
      fault_count_q <= fault_count_d;
      fault_addr_q  <= fault_addr_d;
    end
  end

  assign data_in     = data_in_q;
  assign fault       = fault_q;
  assign fault_count = fault_count_q;
  assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_mips_unified_memory.sv
// Scoreboard bench for mips_unified_memory. For each cycle, the stimulus
// process drives the inputs and pushes the outputs that a reference model
// predicts for that cycle. A separate monitor pops each prediction on the
// falling edge and compares it with the DUT.

module tb_mips_unified_memory;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_addr, instr_in;
  logic [31:0] data_addr, data_out, data_in;
  logic        data_rd_wr;
  logic        load_valid, load_ready;
  logic [31:0] load_addr, load_data;
  logic        fault;
  logic [7:0]  fault_count;
  logic [31:0] fault_addr;

  mips_unified_memory #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset),
    .instr_addr(instr_addr), .instr_in(instr_in),
    .data_addr(data_addr), .data_out(data_out), .data_rd_wr(data_rd_wr),
    .data_in(data_in),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data),
    .fault(fault), .fault_count(fault_count), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr; bit instr_k;
    bit          rdy;   bit rdy_k;
    logic [31:0] din;   bit din_k;
    bit          flt;
    logic [7:0]  cnt;
    logic [31:0] fa;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state. Only words the bench has written are known.
  logic [31:0] m_mem [int];
  logic [31:0] m_din;  bit m_din_k = 1'b1;
  bit          m_flt;
  int          m_cnt;
  logic [31:0] m_fa;
  bit          m_prst; bit m_prst_k = 1'b0;

  function automatic bit m_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] == 2'b00) && (off < 32'(4 * DEPTH));
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off >> 2);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, want, $time);
    end
  endtask

  // Monitor: compares each prediction against what the DUT presents mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.instr_k) chk("instr_in", instr_in, e.instr);
      if (e.rdy_k)   chk("load_ready", {31'b0, load_ready}, {31'b0, e.rdy});
      if (e.din_k)   chk("data_in", data_in, e.din);
      chk("fault", {31'b0, fault}, {31'b0, e.flt});
      chk("fault_count", {24'b0, fault_count}, {24'b0, e.cnt});
      chk("fault_addr", fault_addr, e.fa);
    end
  end

  // Drives one cycle of inputs, predicts the outputs that are visible now,
  // then advances the model to the state after the next clock edge.
  task automatic cyc(input bit rst, input logic [31:0] ia, input logic [31:0] da,
                     input logic [31:0] dw, input bit rdwr, input bit lv,
                     input logic [31:0] la, input logic [31:0] ld);
    exp_t e;
    bit rdy, first_rst;
    int n;
    @(posedge clk); #1;
    reset = rst; instr_addr = ia; data_addr = da; data_out = dw;
    data_rd_wr = rdwr; load_valid = lv; load_addr = la; load_data = ld;

    first_rst = rst && !m_prst;
    rdy = rdwr && !first_rst;
    if (!m_ok(ia))                    begin e.instr = 32'h0; e.instr_k = 1'b1; end
    else if (m_mem.exists(m_idx(ia))) begin e.instr = m_mem[m_idx(ia)]; e.instr_k = 1'b1; end
    else                              begin e.instr = 32'h0; e.instr_k = 1'b0; end
    e.rdy = rdy; e.rdy_k = m_prst_k || !rst;
    e.din = m_din; e.din_k = m_din_k;
    e.flt = m_flt; e.cnt = 8'(m_cnt); e.fa = m_fa;
    exp_q.push_back(e);

    if (rst) begin
      m_din = 32'h0; m_din_k = 1'b1; m_flt = 1'b0; m_cnt = 0; m_fa = 32'h0;
    end else begin
      if (rdwr) begin
        if (!m_ok(da))                    begin m_din = 32'h0; m_din_k = 1'b1; end
        else if (m_mem.exists(m_idx(da))) begin m_din = m_mem[m_idx(da)]; m_din_k = 1'b1; end
        else                              m_din_k = 1'b0;
      end
      n = 0;
      if (!m_ok(ia)) begin n++; m_fa = ia; end
      if (lv && rdy && !m_ok(la)) begin n++; m_fa = la; end
      if (!m_ok(da)) begin n++; m_fa = da; end
      if (n > 0) begin
        m_flt = 1'b1;
        m_cnt = (m_cnt + n > 255) ? 255 : m_cnt + n;
      end
    end
    if (!rst && !rdwr && m_ok(da)) m_mem[m_idx(da)] = dw;
    else if (lv && rdy && m_ok(la)) m_mem[m_idx(la)] = ld;
    m_prst = rst; m_prst_k = 1'b1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
    if (r == 1) return ($urandom_range(0, 1) == 0) ? 32'(32'h1000 + $urandom_range(0, 63) * 4)
                                                   : 32'hFFFF_FFF0;
    return 32'($urandom_range(0, 63) * 4);
  endfunction

  initial begin
    reset = 1'b1; instr_addr = 0; data_addr = 0; data_out = 0; data_rd_wr = 1'b1;
    load_valid = 1'b0; load_addr = 0; load_data = 0;

    // Power-up reset, then a fresh reset cycle so that the ready gap can be seen.
    cyc(1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    idle();
    cyc(1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20,  32'h1111_2222);
    cyc(1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20,  32'h1111_2222);
    cyc(1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0,   32'h0BAD_0000);
    cyc(1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h200, 32'h2020_0200);
    cyc(1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);

    // Write, then read back the same word.
    cyc(1'b0, 32'h0, 32'h100, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 32'h100, 32'h100, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    idle();

    // The host load is held off by a core write, then accepted.
    cyc(1'b0, 32'h0, 32'h104, 32'h5, 1'b0, 1'b1, 32'h108, 32'h77);
    cyc(1'b0, 32'h108, 32'h108, 32'h0, 1'b1, 1'b1, 32'h108, 32'h77);
    cyc(1'b0, 32'h0, 32'h108, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    idle();

    // Misaligned read, then an out-of-range write that must not alias word 0.
    cyc(1'b0, 32'h0, 32'h102, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 32'h0, 32'h1000, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    idle();

    // Three fault events in one cycle, then drive the count into saturation.
    for (int i = 0; i < 101; i++)
      cyc(1'b0, 32'h4000, 32'h5000, 32'h0, 1'b1, 1'b1, 32'h6000, 32'h1);
    idle();

    // Reset in the middle of a write: the word is kept and the state clears.
    cyc(1'b1, 32'h0, 32'h200, 32'h9999_9999, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 32'h0, 32'h200, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 32'h20, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    idle();

    // Randomized traffic on all three ports.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) < 3), rnd_addr(), rnd_addr(), $urandom(),
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4), rnd_addr(), $urandom());
    end
    idle();
    idle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
